updown_counter: RTL and testbench

Parametrised up/down counter: the next generation of the team's fixed 4-bit free-running counter. Adds configurable width and terminal value, direction control, synchronous load/clear, three count modes (wrap, saturate, one-shot) and an optional clock-enable prescaler. Used as a general-purpose timer/event counter inside the design. Its outputs are observed by the same `$write`/VCD-style benches as the original.

---
 rtl/counter_pkg.sv | 22 ++
 rtl/tick_prescaler.sv | 58 +++++
 rtl/updown_counter.sv | 203 ++++++++++++++++++++
 tb/tb_updown_counter.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/counter_pkg.sv
// -----------------------------------------------------------------------------
// counter_pkg
// Shared definitions for updown_counter and its tick prescaler.
//   - Count-mode encodings driven on updown_counter.i_mode
//   - One-shot FSM state encoding
// Optional feature macro used by updown_counter: UPDOWN_COUNTER_PRESCALE_EN
// -----------------------------------------------------------------------------
package counter_pkg;

  // Count modes (i_mode)
  localparam logic [1:0] MODE_WRAP    = 2'b00;
  localparam logic [1:0] MODE_SAT     = 2'b01;
  localparam logic [1:0] MODE_ONESHOT = 2'b10;
  localparam logic [1:0] MODE_HOLD    = 2'b11;

  // One-shot FSM states
  typedef enum logic {
    ST_ARMED = 1'b0,
    ST_DONE  = 1'b1
  } state_e;

endpackage : counter_pkg

// File: rtl/tick_prescaler.sv
// -----------------------------------------------------------------------------
// tick_prescaler
// Produces a one-cycle count tick once every PRESCALE cycles. The first tick
// lands on the PRESCALE-th cycle after reset release or after i_restart.
// Runs continuously; it is not gated by the counter's enable.
//
// Parameters:
//   PRESCALE  tick period in cycles (>= 1); 1 gives a tick every cycle
// Ports:
//   CLK        in   rising-edge clock
//   RST_X      in   asynchronous active-low reset
//   i_restart  in   synchronous phase restart (counter clear/load)
//   o_tick     out  tick, decoded from the registered phase counter
// -----------------------------------------------------------------------------
module tick_prescaler
  import counter_pkg::*;
#(
  parameter int unsigned PRESCALE = 1
) (
  input  logic CLK,
  input  logic RST_X,
  input  logic i_restart,
  output logic o_tick
);

  localparam int unsigned      CW      = $clog2(PRESCALE) + 1;
  localparam logic [CW-1:0]    PH_LAST = CW'(PRESCALE - 1);
  localparam logic [CW-1:0]    PH_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0]    PH_ONE  = CW'(1'b1);

  logic [CW-1:0] phase_q;
  logic [CW-1:0] phase_d;

  // Phase counter next state: restart to 0, otherwise count 0..PRESCALE-1
  always_comb begin
    phase_d = phase_q;
    if (i_restart) begin
      phase_d = PH_ZERO;
    end else if (phase_q == PH_LAST) begin
      phase_d = PH_ZERO;
    end else begin
      phase_d = phase_q + PH_ONE;
    end
  end

  // Phase counter register
  always_ff @(posedge CLK or negedge RST_X) begin
    if (!RST_X) begin
      phase_q <= PH_ZERO;
    end else begin
      phase_q <= phase_d;
    end
  end

  // Tick in the last phase so the first tick is the PRESCALE-th cycle
  assign o_tick = (phase_q == PH_LAST);

endmodule : tick_prescaler

// File: rtl/updown_counter.sv
// -----------------------------------------------------------------------------
// updown_counter
// Parametrised up/down counter with wrap, saturate, one-shot and hold modes,
// synchronous clear/load and an optional tick prescaler.
//
// Optional feature macro: UPDOWN_COUNTER_PRESCALE_EN
//   defined   -> tick_prescaler instantiated, PRESCALE honoured
//   undefined -> tick is 1 every cycle, PRESCALE has no effect
//
// Parameters:
//   WIDTH     counter width (>= 2)
//   MAX_VAL   terminal value for up-count / reload for down-wrap
//   PRESCALE  tick period in cycles (prescaler builds only)
// Ports:
//   CLK         in   rising-edge clock
//   RST_X       in   asynchronous active-low reset
//   i_en        in   count enable, sampled on tick cycles
//   i_up        in   direction, 1 = up
//   i_mode      in   00 wrap, 01 saturate, 10 one-shot, 11 hold
//   i_clr       in   synchronous clear (beats load)
//   i_load      in   synchronous load, value clamped to MAX_VAL
//   i_load_val  in   load value
//   o_cnt       out  count, registered
//   o_tc        out  terminal count, combinational on o_cnt and i_up
//   o_wrap      out  one-cycle wrap pulse, registered
//   o_done      out  one-shot complete level, registered
// -----------------------------------------------------------------------------
module updown_counter
  import counter_pkg::*;
#(
  parameter int unsigned      WIDTH    = 8,
  parameter logic [WIDTH-1:0] MAX_VAL  = {WIDTH{1'b1}},
  parameter int unsigned      PRESCALE = 1
) (
  input  logic             CLK,
  input  logic             RST_X,
  input  logic             i_en,
  input  logic             i_up,
  input  logic [1:0]       i_mode,
  input  logic             i_clr,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_val,
  output logic [WIDTH-1:0] o_cnt,
  output logic             o_tc,
  output logic             o_wrap,
  output logic             o_done
);

  localparam logic [WIDTH-1:0] CNT_ZERO = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] CNT_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             wrap_q, wrap_d;
  logic             done_q, done_d;
  state_e           state_q, state_d;

  logic             tick_s;
  logic             step_s;
  logic [WIDTH-1:0] cnt_eff_s;
  logic             at_top_s;
  logic             at_bot_s;
  logic [WIDTH-1:0] sat_next_s;
  logic [WIDTH-1:0] term_s;

`ifdef UPDOWN_COUNTER_PRESCALE_EN
  tick_prescaler #(
    .PRESCALE (PRESCALE)
  ) u_tick_prescaler (
    .CLK       (CLK),
    .RST_X     (RST_X),
    .i_restart (i_clr | i_load),
    .o_tick    (tick_s)
  );
`else
  // Every cycle is a tick; PRESCALE is kept in the parameter list so both
  // builds share one instantiation template.
  localparam bit PRESCALE_SET = (PRESCALE != 0);
  assign tick_s = 1'b1 | PRESCALE_SET;
`endif

  assign step_s = tick_s & i_en;

  // A count above MAX_VAL can only come from misconfiguration; stepping from
  // it behaves as if the count were MAX_VAL.
  assign cnt_eff_s = (cnt_q > MAX_VAL) ? MAX_VAL : cnt_q;
  assign at_top_s  = (cnt_eff_s == MAX_VAL);
  assign at_bot_s  = (cnt_eff_s == CNT_ZERO);
  assign term_s    = i_up ? MAX_VAL : CNT_ZERO;

  // Saturating +/-1 step, shared by saturate and one-shot modes
  always_comb begin
    sat_next_s = cnt_eff_s;
    if (i_up) begin
      if (at_top_s) begin
        sat_next_s = MAX_VAL;
      end else begin
        sat_next_s = cnt_eff_s + CNT_ONE;
      end
    end else begin
      if (at_bot_s) begin
        sat_next_s = CNT_ZERO;
      end else begin
        sat_next_s = cnt_eff_s - CNT_ONE;
      end
    end
  end

  // Next count, one-shot FSM next state and wrap/done flags
  always_comb begin
    cnt_d   = cnt_q;
    state_d = state_q;
    wrap_d  = 1'b0;
    done_d  = done_q;
    if (i_clr) begin
      cnt_d   = CNT_ZERO;
      state_d = ST_ARMED;
      done_d  = 1'b0;
    end else if (i_load) begin
      cnt_d   = (i_load_val > MAX_VAL) ? MAX_VAL : i_load_val;
      state_d = ST_ARMED;
      done_d  = 1'b0;
    end else begin
      // Any mode other than one-shot re-arms the FSM and drops o_done
      if (i_mode != MODE_ONESHOT) begin
        state_d = ST_ARMED;
        done_d  = 1'b0;
      end else begin
        state_d = state_q;
        done_d  = done_q;
      end
      if (step_s) begin
        case (i_mode)
          MODE_WRAP: begin
            if (i_up) begin
              if (at_top_s) begin
                cnt_d  = CNT_ZERO;
                wrap_d = 1'b1;
              end else begin
                cnt_d  = cnt_eff_s + CNT_ONE;
                wrap_d = 1'b0;
              end
            end else begin
              if (at_bot_s) begin
                cnt_d  = MAX_VAL;
                wrap_d = 1'b1;
              end else begin
                cnt_d  = cnt_eff_s - CNT_ONE;
                wrap_d = 1'b0;
              end
            end
          end
          MODE_SAT: begin
            cnt_d = sat_next_s;
          end
          MODE_ONESHOT: begin
            if (state_q == ST_ARMED) begin
              cnt_d = sat_next_s;
              // Reaching the terminal completes the shot on this edge
              if (sat_next_s == term_s) begin
                state_d = ST_DONE;
                done_d  = 1'b1;
              end else begin
                state_d = ST_ARMED;
                done_d  = 1'b0;
              end
            end else begin
              cnt_d = cnt_q;
            end
          end
          MODE_HOLD: begin
            cnt_d = cnt_q;
          end
          default: begin
            cnt_d = cnt_q;
          end
        endcase
      end else begin
        cnt_d = cnt_q;
      end
    end
  end

  // Count, FSM and flag registers
  always_ff @(posedge CLK or negedge RST_X) begin
    if (!RST_X) begin
      cnt_q   <= CNT_ZERO;
      state_q <= ST_ARMED;
      wrap_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      state_q <= state_d;
      wrap_q  <= wrap_d;
      done_q  <= done_d;
    end
  end

  assign o_cnt  = cnt_q;
  assign o_wrap = wrap_q;
  assign o_done = done_q;
  assign o_tc   = i_up ? (cnt_q == MAX_VAL) : (cnt_q == CNT_ZERO);

endmodule : updown_counter

// File: tb/tb_updown_counter.sv
// Scoreboard bench for updown_counter (WIDTH=4, MAX_VAL=9). Stimulus drives
// inputs on the falling edge and queues the hand-computed result expected
// after the next rising edge; the monitor pops and compares 1 time unit after
// each rising edge. A second instance with PRESCALE=3 is checked only when
// UPDOWN_COUNTER_PRESCALE_EN is defined.
module tb_updown_counter;
  import counter_pkg::*;

  typedef struct {
    bit         sel;
    logic [3:0] cnt;
    logic       wrap;
    logic       done;
    logic       tc;
    string      name;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic       up = 1'b1;
  logic [1:0] mode = MODE_WRAP;
  logic       clr = 1'b0;
  logic       load = 1'b0;
  logic [3:0] load_val = 4'd0;

  logic [3:0] cnt;
  logic       tc, wrap, done;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  updown_counter #(
    .WIDTH    (4),
    .MAX_VAL  (4'd9),
    .PRESCALE (1)
  ) u_dut (
    .CLK        (clk),
    .RST_X      (rst_n),
    .i_en       (en),
    .i_up       (up),
    .i_mode     (mode),
    .i_clr      (clr),
    .i_load     (load),
    .i_load_val (load_val),
    .o_cnt      (cnt),
    .o_tc       (tc),
    .o_wrap     (wrap),
    .o_done     (done)
  );

`ifdef UPDOWN_COUNTER_PRESCALE_EN
  logic [3:0] ps_cnt;
  logic       ps_tc, ps_wrap, ps_done;

  updown_counter #(
    .WIDTH    (4),
    .MAX_VAL  (4'd9),
    .PRESCALE (3)
  ) u_dut_ps (
    .CLK        (clk),
    .RST_X      (rst_n),
    .i_en       (en),
    .i_up       (up),
    .i_mode     (mode),
    .i_clr      (clr),
    .i_load     (load),
    .i_load_val (load_val),
    .o_cnt      (ps_cnt),
    .o_tc       (ps_tc),
    .o_wrap     (ps_wrap),
    .o_done     (ps_done)
  );
`endif

  task automatic compare(input string name, input logic [6:0] act, input logic [6:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_errors++;
      $display("FAIL %s: got cnt=%0d wrap=%b done=%b tc=%b, expected cnt=%0d wrap=%b done=%b tc=%b",
               name, act[6:3], act[2], act[1], act[0], expv[6:3], expv[2], expv[1], expv[0]);
    end
  endtask

  // Drive one cycle of inputs and queue the result expected after the edge
  task automatic cyc(input logic e, input logic u, input logic [1:0] m,
                     input logic c, input logic l, input logic [3:0] v,
                     input logic [3:0] x_cnt, input logic x_wrap,
                     input logic x_done, input logic x_tc,
                     input string name, input bit sel = 1'b0);
    exp_t ent;
    @(negedge clk);
    en = e; up = u; mode = m; clr = c; load = l; load_val = v;
    ent.sel = sel; ent.cnt = x_cnt; ent.wrap = x_wrap;
    ent.done = x_done; ent.tc = x_tc; ent.name = name;
    sb_q.push_back(ent);
  endtask

  // Monitor: one queued expectation per rising edge
  initial begin
    exp_t e;
    logic [6:0] act;
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        act = {cnt, wrap, done, tc};
`ifdef UPDOWN_COUNTER_PRESCALE_EN
        if (e.sel) act = {ps_cnt, ps_wrap, ps_done, ps_tc};
`endif
        compare(e.name, act, {e.cnt, e.wrap, e.done, e.tc});
      end
    end
  end

  initial begin
    int ps_exp[12];
    #2;
    compare("reset_state", {cnt, wrap, done, tc}, {4'd0, 1'b0, 1'b0, 1'b0});
    @(negedge clk);
    rst_n = 1'b1;

    // Wrap up: 1..9 then 9->0 with wrap pulse
    for (int i = 1; i <= 10; i++)
      cyc(1'b1, 1'b1, MODE_WRAP, 1'b0, 1'b0, 4'd0,
          4'(i % 10), (i == 10), 1'b0, ((i % 10) == 9), "wrap_up");

    // Wrap down from load 3: 3,2,1,0,9,8
    cyc(1'b1, 1'b0, MODE_WRAP, 1'b0, 1'b1, 4'd3, 4'd3, 1'b0, 1'b0, 1'b0, "wrap_dn_load");
    cyc(1'b1, 1'b0, MODE_WRAP, 1'b0, 1'b0, 4'd0, 4'd2, 1'b0, 1'b0, 1'b0, "wrap_dn");
    cyc(1'b1, 1'b0, MODE_WRAP, 1'b0, 1'b0, 4'd0, 4'd1, 1'b0, 1'b0, 1'b0, "wrap_dn");
    cyc(1'b1, 1'b0, MODE_WRAP, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b1, "wrap_dn_zero");
    cyc(1'b1, 1'b0, MODE_WRAP, 1'b0, 1'b0, 4'd0, 4'd9, 1'b1, 1'b0, 1'b0, "wrap_dn_wrap");
    cyc(1'b1, 1'b0, MODE_WRAP, 1'b0, 1'b0, 4'd0, 4'd8, 1'b0, 1'b0, 1'b0, "wrap_dn_after");

    // Saturate up from 7, clamped load, saturate down at 0
    cyc(1'b1, 1'b1, MODE_SAT, 1'b0, 1'b1, 4'd7, 4'd7, 1'b0, 1'b0, 1'b0, "sat_load7");
    cyc(1'b1, 1'b1, MODE_SAT, 1'b0, 1'b0, 4'd0, 4'd8, 1'b0, 1'b0, 1'b0, "sat_up");
    cyc(1'b1, 1'b1, MODE_SAT, 1'b0, 1'b0, 4'd0, 4'd9, 1'b0, 1'b0, 1'b1, "sat_up");
    cyc(1'b1, 1'b1, MODE_SAT, 1'b0, 1'b0, 4'd0, 4'd9, 1'b0, 1'b0, 1'b1, "sat_hold_top");
    cyc(1'b1, 1'b1, MODE_SAT, 1'b0, 1'b0, 4'd0, 4'd9, 1'b0, 1'b0, 1'b1, "sat_hold_top");
    cyc(1'b1, 1'b1, MODE_SAT, 1'b0, 1'b1, 4'd12, 4'd9, 1'b0, 1'b0, 1'b1, "load_clamp");
    cyc(1'b1, 1'b0, MODE_SAT, 1'b1, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b1, "sat_clr");
    cyc(1'b1, 1'b0, MODE_SAT, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b1, "sat_hold_bot");

    // One-shot up from clear: done on the edge producing 9, then hold
    cyc(1'b1, 1'b1, MODE_ONESHOT, 1'b1, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, "os_clr");
    for (int i = 1; i <= 9; i++)
      cyc(1'b1, 1'b1, MODE_ONESHOT, 1'b0, 1'b0, 4'd0,
          4'(i), 1'b0, (i == 9), (i == 9), "os_up");
    for (int i = 0; i < 5; i++)
      cyc(1'b1, 1'b1, MODE_ONESHOT, 1'b0, 1'b0, 4'd0, 4'd9, 1'b0, 1'b1, 1'b1, "os_done_hold");
    cyc(1'b1, 1'b1, MODE_ONESHOT, 1'b0, 1'b1, 4'd4, 4'd4, 1'b0, 1'b0, 1'b0, "os_reload");
    for (int i = 5; i <= 9; i++)
      cyc(1'b1, 1'b1, MODE_ONESHOT, 1'b0, 1'b0, 4'd0,
          4'(i), 1'b0, (i == 9), (i == 9), "os_up2");
    cyc(1'b0, 1'b1, MODE_WRAP, 1'b0, 1'b0, 4'd0, 4'd9, 1'b0, 1'b0, 1'b1, "leave_oneshot");
    cyc(1'b1, 1'b1, MODE_HOLD, 1'b0, 1'b0, 4'd0, 4'd9, 1'b0, 1'b0, 1'b1, "hold_mode");

    // One-shot down: 2,1,0 (done), 0
    cyc(1'b1, 1'b0, MODE_ONESHOT, 1'b0, 1'b1, 4'd2, 4'd2, 1'b0, 1'b0, 1'b0, "os_dn_load");
    cyc(1'b1, 1'b0, MODE_ONESHOT, 1'b0, 1'b0, 4'd0, 4'd1, 1'b0, 1'b0, 1'b0, "os_dn");
    cyc(1'b1, 1'b0, MODE_ONESHOT, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0, 1'b1, 1'b1, "os_dn_done");
    cyc(1'b1, 1'b0, MODE_ONESHOT, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0, 1'b1, 1'b1, "os_dn_hold");

    // Clear beats load mid-count; enable low holds
    cyc(1'b1, 1'b1, MODE_WRAP, 1'b0, 1'b1, 4'd3, 4'd3, 1'b0, 1'b0, 1'b0, "mid_load");
    cyc(1'b1, 1'b1, MODE_WRAP, 1'b0, 1'b0, 4'd0, 4'd4, 1'b0, 1'b0, 1'b0, "mid_step");
    cyc(1'b1, 1'b1, MODE_WRAP, 1'b1, 1'b1, 4'd5, 4'd0, 1'b0, 1'b0, 1'b0, "clr_and_load");
    cyc(1'b0, 1'b1, MODE_WRAP, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, "en_low_hold");

    // Async reset while DONE at 9
    cyc(1'b1, 1'b1, MODE_ONESHOT, 1'b0, 1'b1, 4'd7, 4'd7, 1'b0, 1'b0, 1'b0, "pre_rst_load");
    cyc(1'b1, 1'b1, MODE_ONESHOT, 1'b0, 1'b0, 4'd0, 4'd8, 1'b0, 1'b0, 1'b0, "pre_rst_up");
    cyc(1'b1, 1'b1, MODE_ONESHOT, 1'b0, 1'b0, 4'd0, 4'd9, 1'b0, 1'b1, 1'b1, "pre_rst_done");
    @(posedge clk);
    #3;
    en = 1'b0;
    rst_n = 1'b0;
    #1;
    compare("async_reset", {cnt, wrap, done, tc}, {4'd0, 1'b0, 1'b0, 1'b0});
    @(negedge clk);
    rst_n = 1'b1;
    cyc(1'b1, 1'b1, MODE_WRAP, 1'b0, 1'b0, 4'd0, 4'd1, 1'b0, 1'b0, 1'b0, "resume");

`ifdef UPDOWN_COUNTER_PRESCALE_EN
    // PRESCALE=3: step every 3rd cycle, en low on one tick skips one step,
    // load restarts the phase
    ps_exp = '{0, 0, 1, 1, 1, 2, 2, 2, 2, 2, 2, 3};
    cyc(1'b1, 1'b1, MODE_WRAP, 1'b1, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, "ps_clr", 1'b1);
    for (int i = 0; i < 12; i++)
      cyc((i != 8), 1'b1, MODE_WRAP, 1'b0, 1'b0, 4'd0,
          4'(ps_exp[i]), 1'b0, 1'b0, 1'b0, "ps_step", 1'b1);
    cyc(1'b1, 1'b1, MODE_WRAP, 1'b0, 1'b1, 4'd5, 4'd5, 1'b0, 1'b0, 1'b0, "ps_load", 1'b1);
    cyc(1'b1, 1'b1, MODE_WRAP, 1'b0, 1'b0, 4'd0, 4'd5, 1'b0, 1'b0, 1'b0, "ps_phase", 1'b1);
    cyc(1'b1, 1'b1, MODE_WRAP, 1'b0, 1'b0, 4'd0, 4'd5, 1'b0, 1'b0, 1'b0, "ps_phase", 1'b1);
    cyc(1'b1, 1'b1, MODE_WRAP, 1'b0, 1'b0, 4'd0, 4'd6, 1'b0, 1'b0, 1'b0, "ps_phase", 1'b1);
`endif

    // Drain the scoreboard within a bounded number of cycles
    for (int i = 0; i < 4 && sb_q.size() != 0; i++) @(posedge clk);
    #2;
    n_checks++;
    if (sb_q.size() != 0) begin
      n_errors++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_updown_counter
